// File: rtl/in_service_control.sv
// rtl/in_service_control.sv - INTA# sequencing, vector drive and in-service/rotation bookkeeping
module in_service_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       interrupt_acknowledge_n,
    input  logic [4:0] interrupt_vector_base,
    input  logic       auto_eoi_config,
    input  logic       auto_rotate_mode,
    input  logic       nonspecific_eoi,
    input  logic       specific_eoi,
    input  logic       rotate_on_eoi,
    input  logic [2:0] eoi_level,
    input  logic       set_priority,
    output logic       interrupt_to_cpu,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] vector_out,
    output logic       vector_out_enable
);

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t     state, state_next;
    logic       inta_prev, inta_fall, inta_rise;
    logic [2:0] ack_level, ack_level_next;
    logic       spurious, spurious_next;
    logic [7:0] isr_set, isr_clear;
    logic [2:0] rotate_next;
    logic       vec_load, vec_done;
    logic [2:0] request_level, hlis_level, scan_level;

    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    assign inta_fall     = inta_prev & ~interrupt_acknowledge_n;
    assign inta_rise     = ~inta_prev & interrupt_acknowledge_n;
    assign request_level = encode(interrupt);
    assign hlis_level    = encode(highest_level_in_service);

    // Walk from lowest to highest priority so the highest-priority set bit is written last.
    always_comb begin
        highest_level_in_service = 8'h00;
        scan_level = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            scan_level = priority_rotate + 3'(k);
            if (in_service_register[scan_level])
                highest_level_in_service = 8'b1 << scan_level;
        end
    end

    always_comb begin
        state_next     = state;
        ack_level_next = ack_level;
        spurious_next  = spurious;
        isr_set        = 8'h00;
        isr_clear      = 8'h00;
        rotate_next    = priority_rotate;
        vec_load       = 1'b0;
        vec_done       = 1'b0;

        case (state)
            IDLE: if (inta_fall) begin
                state_next = ACK1;
                if (interrupt == 8'h00) begin
                    ack_level_next = 3'd7;
                    spurious_next  = 1'b1;
                end else begin
                    ack_level_next = request_level;
                    spurious_next  = 1'b0;
                    isr_set        = 8'b1 << request_level;
                end
            end
            ACK1: if (inta_rise) state_next = GAP;
            GAP: if (inta_fall) begin
                state_next = ACK2;
                vec_load   = 1'b1;
            end
            ACK2: if (inta_rise) begin
                state_next = IDLE;
                vec_done   = 1'b1;
                if (auto_eoi_config && !spurious) begin
                    isr_clear = 8'b1 << ack_level;
                    if (auto_rotate_mode) rotate_next = ack_level;
                end
            end
            default: state_next = IDLE;
        endcase

        // Later assignments override earlier ones: set_priority > EOI rotate > auto-rotate.
        if (specific_eoi) begin
            isr_clear = isr_clear | (8'b1 << eoi_level);
            if (rotate_on_eoi) rotate_next = eoi_level;
        end else if (nonspecific_eoi && highest_level_in_service != 8'h00) begin
            isr_clear = isr_clear | highest_level_in_service;
            if (rotate_on_eoi) rotate_next = hlis_level;
        end
        if (set_priority) rotate_next = eoi_level;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            inta_prev           <= 1'b1;
            ack_level           <= 3'd7;
            spurious            <= 1'b0;
            in_service_register <= 8'h00;
            priority_rotate     <= 3'b111;
            vector_out          <= 8'h00;
            vector_out_enable   <= 1'b0;
            interrupt_to_cpu    <= 1'b0;
        end else begin
            state               <= state_next;
            inta_prev           <= interrupt_acknowledge_n;
            ack_level           <= ack_level_next;
            spurious            <= spurious_next;
            in_service_register <= (in_service_register & ~isr_clear) | isr_set;
            priority_rotate     <= rotate_next;
            if (vec_load) begin
                vector_out        <= {interrupt_vector_base, ack_level};
                vector_out_enable <= 1'b1;
            end else if (vec_done) begin
                vector_out_enable <= 1'b0;
            end
            interrupt_to_cpu    <= (state == IDLE) && (interrupt != 8'h00);
        end
    end

endmodule

// File: doc/in_service_control.md
# in_service_control

CPU-side acknowledge and in-service bookkeeping for the 8259A-compatible interrupt controller. It takes the one-hot winning request from the priority resolver and raises INT to the CPU. It then runs the two-pulse 8086-mode INTA sequence, drives the vector byte, and maintains the in-service register, highest-level-in-service and rotation state that feed back into the resolver. It also performs specific/non-specific EOI, automatic EOI and priority rotation.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- interrupt  in  8  one-hot resolved request from the priority resolver (all-zero = none)
- interrupt_acknowledge_n  in  1  INTA# pin, already synchronised to clock, active-low
- interrupt_vector_base  in  5  ICW2 T7..T3
- auto_eoi_config  in  1  ICW4 AEOI
- auto_rotate_mode  in  1  rotate-on-AEOI enable
- nonspecific_eoi  in  1  one-cycle pulse: clear highest-priority in-service bit
- specific_eoi  in  1  one-cycle pulse: clear bit eoi_level
- rotate_on_eoi  in  1  qualifies either EOI pulse: also rotate
- eoi_level  in  3  level for specific EOI
- set_priority  in  1  one-cycle pulse: priority_rotate <= eoi_level, no ISR change
- interrupt_to_cpu  out  1  INT pin, registered
- in_service_register  out  8  ISR to resolver
- highest_level_in_service  out  8  one-hot highest-priority ISR bit (combinational from ISR, priority_rotate)
- priority_rotate  out  3  lowest-priority level; 3'b111 = IR0 highest
- vector_out  out  8  vector byte
- vector_out_enable  out  1  data-bus drive enable

## Operation
- Edge detect: inta_prev register (reset 1). Fall = inta_prev & ~interrupt_acknowledge_n. Rise = ~inta_prev & interrupt_acknowledge_n.
- FSM states: IDLE, ACK1 (first pulse low), GAP (between pulses), ACK2 (second pulse low).
  - IDLE -> ACK1 on fall: latch ack_level = encode(interrupt). If interrupt == 0, this is a spurious ack: ack_level = 7 and the ISR is not set. Otherwise ISR[ack_level] <= 1.
  - ACK1 -> GAP on rise.
  - GAP -> ACK2 on fall: vector_out <= {interrupt_vector_base, ack_level}, vector_out_enable <= 1.
  - ACK2 -> IDLE on rise: vector_out_enable <= 0.
    - If auto_eoi_config and not spurious: clear ISR[ack_level].
    - If auto_rotate_mode is also set: priority_rotate <= ack_level.
- interrupt_to_cpu:
  - In IDLE it is registered from |interrupt.
  - It is forced to 0 from the cycle after the ACK1 entry until the return to IDLE.
- highest_level_in_service:
  - Scan ISR starting at level (priority_rotate+1) mod 8, wrapping.
  - The first set bit is the one-hot result; if ISR is 0, the result is 0.
- Non-specific EOI:
  - Clear the bit given by highest_level_in_service.
  - If rotate_on_eoi is set, priority_rotate <= that level.
  - With ISR == 0, nothing changes.
- Specific EOI:
  - Clear ISR[eoi_level].
  - If rotate_on_eoi is set, priority_rotate <= eoi_level.
- Simultaneous events:
  - An EOI and an ISR set in the same cycle are both applied; if they target the same bit, the set wins.
  - Rotation priority, highest first: set_priority > EOI rotate > auto-rotate.
  - Both EOI pulses together: specific wins.
- A fall seen in ACK1 or ACK2 (protocol violation) is ignored.
- Reset mid-sequence:
  - FSM -> IDLE.
  - ISR = 0, priority_rotate = 3'b111.
  - vector_out = 0, vector_out_enable = 0, interrupt_to_cpu = 0.

## Timing
- Reset values:
  - interrupt_to_cpu 0, in_service_register 0, priority_rotate 3'b111.
  - vector_out 8'h00, vector_out_enable 0.
  - highest_level_in_service 0 (follows from ISR = 0).
  - FSM in IDLE, inta_prev 1.
- Request to INT: interrupt nonzero at cycle N -> interrupt_to_cpu high at N+1.
- INTA# sampled low at cycle N following high at N-1:
  - The FSM transition, ISR set and vector register update at the N+1 rising edge.
  - These are visible during cycle N+1.
- EOI and set_priority pulses take effect at the next edge.
- highest_level_in_service reflects the new ISR in the same cycle the ISR changes.
- vector_out_enable:
  - High from the cycle after the second fall through the cycle in which the rise is sampled.
  - Low the cycle after that.
- Minimum INTA# low/high width is 1 cycle; no upper bound.

## Test plan
- interrupt=8'h04, base=5'b01000, two INTA# pulses -> INT high 1 cycle after request, low after first fall; ISR=8'h04; vector_out=8'h42 with enable during second pulse.
- Same as above with auto_eoi_config=1, auto_rotate_mode=1 -> ISR returns to 0 after second rise; priority_rotate=3'd2.
- ISR=8'h09, priority_rotate=3'd0, nonspecific_eoi with rotate_on_eoi -> highest_level_in_service=8'h08 before; ISR=8'h01, priority_rotate=3'd3 after.
- INTA# sequence with interrupt=0 -> vector_out={base,3'd7}; ISR unchanged 0.
- specific_eoi eoi_level=2 in the same cycle the first fall sets ISR[5] -> ISR=8'h20 (bit 2 cleared, bit 5 set); a same-bit collision leaves the bit set.
- reset asserted during GAP -> next cycle all outputs at reset values; a later full INTA sequence works normally.
